regfile_wr_arbiter: RTL and testbench

- Shares the general-purpose register file's single write port between two writeback requesters: port 0 is ALU writeback, port 1 is memory-load writeback.
- Each port has a valid/ready handshake and a 1-entry holding register.
- A round-robin arbiter moves one held entry per cycle into a registered output stage that drives the register file write port.
- Also exports a pending-write scoreboard mask, so the issue logic can stall reads of registers whose writes have not landed.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/wr_hold_slot.sv | 61 ++++++
 rtl/regfile_wr_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file write-port arbiter:
// register file geometry, the held write request type and port indices.
package regfile_pkg;

    localparam int NREG = 13;
    localparam int AW   = 4;
    localparam int DW   = 16;

    localparam int PORT_ALU = 0;
    localparam int PORT_MEM = 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/wr_hold_slot.sv
// One-entry holding register for a writeback requester.
// Accepts a request whenever it is empty or being drained this cycle, drops
// requests that target a nonexistent register and flags them for one cycle.
module wr_hold_slot
    import regfile_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_data,
    input  logic          i_grant,
    output logic          o_held,
    output wr_req_t       o_entry,
    output logic          o_ready,
    output logic          o_addr_err
);

    logic    r_held;
    logic    r_addr_err;
    wr_req_t r_entry;
    logic    w_ready;
    logic    w_accept;
    logic    w_addr_ok;
    logic    w_load;

    // Ready only looks at registered state, so it never depends on i_valid.
    assign w_ready   = ~r_held | i_grant;
    assign w_accept  = i_valid & w_ready;
    assign w_addr_ok = (32'(i_addr) < 32'(NREG));
    assign w_load    = w_accept & w_addr_ok;

    // Occupancy flag and invalid-address pulse; a refill in the granted cycle keeps the slot full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_held     <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_accept & ~w_addr_ok;
            if (w_load) begin
                r_held <= 1'b1;
            end else if (i_grant) begin
                r_held <= 1'b0;
            end
        end
    end

    // Entry payload; only meaningful while r_held is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_entry.addr <= i_addr;
            r_entry.data <= i_data;
        end
    end

    assign o_held     = r_held;
    assign o_entry    = r_entry;
    assign o_ready    = w_ready;
    assign o_addr_err = r_addr_err;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file write port between ALU writeback (port 0) and
// load writeback (port 1). Each port has a one-entry slot; a round-robin
// arbiter moves one held entry per cycle into a registered write stage.
// pending_mask marks every register with a write still held or in flight.
module regfile_wr_arbiter #(
    parameter int NREG = regfile_pkg::NREG,
    parameter int DW   = regfile_pkg::DW,
    parameter int AW   = regfile_pkg::AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_addr,
    input  logic [DW-1:0]   req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [AW-1:0]   req1_addr,
    input  logic [DW-1:0]   req1_data,
    output logic            req1_ready,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [DW-1:0]   wr_data,
    output logic [NREG-1:0] pending_mask,
    output logic [1:0]      addr_err
);

    import regfile_pkg::*;

    logic    w_held0;
    logic    w_held1;
    wr_req_t w_entry0;
    wr_req_t w_entry1;
    logic    w_grant0;
    logic    w_grant1;
    logic    w_err0;
    logic    w_err1;

    logic          r_last_grant;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;

    wr_hold_slot u_slot_alu (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (req0_valid),
        .i_addr     (req0_addr),
        .i_data     (req0_data),
        .i_grant    (w_grant0),
        .o_held     (w_held0),
        .o_entry    (w_entry0),
        .o_ready    (req0_ready),
        .o_addr_err (w_err0)
    );

    wr_hold_slot u_slot_mem (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (req1_valid),
        .i_addr     (req1_addr),
        .i_data     (req1_data),
        .i_grant    (w_grant1),
        .o_held     (w_held1),
        .o_entry    (w_entry1),
        .o_ready    (req1_ready),
        .o_addr_err (w_err1)
    );

    // Round-robin: under contention the port that did not win last time goes next.
    always_comb begin
        w_grant0 = w_held0 & (~w_held1 | r_last_grant);
        w_grant1 = w_held1 & (~w_held0 | ~r_last_grant);
    end

    // Remember the most recent winner; reset favours port 0 for the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_grant0) begin
            r_last_grant <= 1'b0;
        end else if (w_grant1) begin
            r_last_grant <= 1'b1;
        end
    end

    // Registered write stage; address/data hold their last value on idle cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_grant0 | w_grant1;
            if (w_grant0) begin
                r_wr_addr <= w_entry0.addr;
                r_wr_data <= w_entry0.data;
            end else if (w_grant1) begin
                r_wr_addr <= w_entry1.addr;
                r_wr_data <= w_entry1.data;
            end
        end
    end

    // Pending writes: both holding slots plus the write currently presented to the file.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < NREG; i++) begin
            pending_mask[i] = (w_held0 && (w_entry0.addr == AW'(i))) ||
                              (w_held1 && (w_entry1.addr == AW'(i))) ||
                              (r_wr_en && (r_wr_addr == AW'(i)));
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;

    always_comb begin
        addr_err           = 2'b00;
        addr_err[PORT_ALU] = w_err0;
        addr_err[PORT_MEM] = w_err1;
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset state, single write latency,
// contention order, invalid address, same-address ordering, streaming and
// mid-flight reset.
module tb_regfile_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [3:0]  req0_addr;
    logic [15:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [3:0]  req1_addr;
    logic [15:0] req1_data;
    logic        req1_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [12:0] pending_mask;
    logic [1:0]  addr_err;

    int n_checks;
    int n_fail;
    int cyc_cnt;
    int log_addr[$];
    int log_data[$];
    int log_cyc[$];

    regfile_wr_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .pending_mask (pending_mask),
        .addr_err     (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write that lands in the register file at a clock edge.
    always @(posedge clk) begin
        cyc_cnt = cyc_cnt + 1;
        if (wr_en === 1'b1) begin
            log_addr.push_back(int'(wr_addr));
            log_data.push_back(int'(wr_data));
            log_cyc.push_back(cyc_cnt);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = '0;
        req1_addr  = '0;
        req0_data  = '0;
        req1_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int          a0[3];
    int          a1[3];
    int          exp_order[6];
    logic [5:0]  exp_r0;
    logic [5:0]  exp_r1;
    int          p0;
    int          p1;
    logic        acc0;
    logic        acc1;
    int          rf[16];
    int          bad_cnt;
    int          gap_bad;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc_cnt  = 0;
        a0 = '{1, 2, 3};
        a1 = '{4, 5, 6};
        exp_order = '{1, 4, 2, 5, 3, 6};
        exp_r0 = 6'b110101;
        exp_r1 = 6'b101010;

        // Reset state
        do_reset();
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_mask", pending_mask, 0);
        check_eq("rst_err", addr_err, 0);
        check_eq("rst_ready0", req0_ready, 1);
        check_eq("rst_ready1", req1_ready, 1);

        // Test 1: single write latency and mask lifetime
        req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 16'hA5A5;
        tick();
        req0_valid = 1'b0;
        check_eq("t1_e0_wr_en", wr_en, 0);
        check_eq("t1_e0_mask", pending_mask, 32'h0008);
        tick();
        check_eq("t1_e1_wr_en", wr_en, 1);
        check_eq("t1_e1_addr", wr_addr, 3);
        check_eq("t1_e1_data", wr_data, 32'hA5A5);
        check_eq("t1_e1_mask", pending_mask, 32'h0008);
        tick();
        check_eq("t1_e2_wr_en", wr_en, 0);
        check_eq("t1_e2_mask", pending_mask, 0);
        check_eq("t1_e2_addr_hold", wr_addr, 3);

        // Test 2: both ports streaming, strict alternation from port 0
        do_reset();
        clear_log();
        p0 = 0; p1 = 0;
        for (int k = 1; k <= 8; k++) begin
            req0_valid = (p0 < 3);
            req0_addr  = (p0 < 3) ? 4'(a0[p0]) : 4'd0;
            req0_data  = (p0 < 3) ? 16'(32'h1000 + a0[p0]) : 16'h0;
            req1_valid = (p1 < 3);
            req1_addr  = (p1 < 3) ? 4'(a1[p1]) : 4'd0;
            req1_data  = (p1 < 3) ? 16'(32'h2000 + a1[p1]) : 16'h0;
            acc0 = req0_valid & req0_ready;
            acc1 = req1_valid & req1_ready;
            tick();
            if (acc0) p0++;
            if (acc1) p1++;
            if (k <= 6) begin
                check_eq($sformatf("t2_ready0_c%0d", k), req0_ready, exp_r0[k-1]);
                check_eq($sformatf("t2_ready1_c%0d", k), req1_ready, exp_r1[k-1]);
            end
        end
        idle_inputs();
        check_eq("t2_nwrites", log_addr.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < log_addr.size()) begin
                check_eq($sformatf("t2_order_%0d", i), log_addr[i], exp_order[i]);
                check_eq($sformatf("t2_data_%0d", i), log_data[i],
                         (i % 2 == 0) ? 32'h1000 + exp_order[i] : 32'h2000 + exp_order[i]);
            end
        end
        check_eq("t2_mask_drained", pending_mask, 0);

        // Test 3: invalid address on port 1 is consumed and flagged
        clear_log();
        req1_valid = 1'b1; req1_addr = 4'd13; req1_data = 16'h1234;
        check_eq("t3_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        check_eq("t3_err", addr_err, 2'b10);
        check_eq("t3_wr_en0", wr_en, 0);
        check_eq("t3_mask0", pending_mask, 0);
        tick();
        check_eq("t3_err_clear", addr_err, 0);
        check_eq("t3_wr_en1", wr_en, 0);
        check_eq("t3_mask1", pending_mask, 0);
        check_eq("t3_nwrites", log_addr.size(), 0);

        // Test 4: same address on both ports with last grant on port 0
        req0_valid = 1'b1; req0_addr = 4'd9; req0_data = 16'h0909;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        clear_log();
        req0_valid = 1'b1; req0_addr = 4'd7; req0_data = 16'h0001;
        req1_valid = 1'b1; req1_addr = 4'd7; req1_data = 16'h0002;
        tick();
        idle_inputs();
        check_eq("t4_mask_c0", pending_mask, 32'h0080);
        check_eq("t4_wr_en_c0", wr_en, 0);
        tick();
        check_eq("t4_mask_c1", pending_mask, 32'h0080);
        check_eq("t4_data_c1", wr_data, 32'h0002);
        tick();
        check_eq("t4_mask_c2", pending_mask, 32'h0080);
        check_eq("t4_data_c2", wr_data, 32'h0001);
        tick();
        check_eq("t4_mask_c3", pending_mask, 0);
        check_eq("t4_wr_en_c3", wr_en, 0);
        for (int i = 0; i < 16; i++) rf[i] = 0;
        for (int i = 0; i < log_addr.size(); i++) rf[log_addr[i]] = log_data[i];
        check_eq("t4_nwrites", log_addr.size(), 2);
        check_eq("t4_final_r7", rf[7], 32'h0001);

        // Test 5: port 0 streams every register back-to-back
        clear_log();
        for (int i = 0; i < 13; i++) begin
            req0_valid = 1'b1;
            req0_addr  = 4'(i);
            req0_data  = 16'(i * 32'h0101);
            check_eq($sformatf("t5_ready0_%0d", i), req0_ready, 1);
            tick();
        end
        idle_inputs();
        tick();
        tick();
        check_eq("t5_nwrites", log_addr.size(), 13);
        gap_bad = 0;
        for (int i = 0; i < log_addr.size(); i++) begin
            check_eq($sformatf("t5_addr_%0d", i), log_addr[i], i);
            check_eq($sformatf("t5_data_%0d", i), log_data[i], i * 32'h0101);
            if (log_cyc[i] != log_cyc[0] + i) gap_bad++;
        end
        check_eq("t5_bubbles", gap_bad, 0);

        // Test 6: reset while both slots are full and a write is in flight
        do_reset();
        clear_log();
        req0_valid = 1'b1; req0_addr = 4'd10; req0_data = 16'hAAAA;
        req1_valid = 1'b1; req1_addr = 4'd11; req1_data = 16'hBBBB;
        tick();
        req0_addr = 4'd12; req0_data = 16'hCCCC;
        req1_valid = 1'b0;
        tick();
        idle_inputs();
        check_eq("t6_pre_wr_en", wr_en, 1);
        check_eq("t6_pre_mask", pending_mask, 32'h1C00);
        rst_n = 1'b0;
        tick();
        check_eq("t6_wr_en", wr_en, 0);
        check_eq("t6_mask", pending_mask, 0);
        check_eq("t6_ready0", req0_ready, 1);
        check_eq("t6_ready1", req1_ready, 1);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check_eq("t6_after_wr_en", wr_en, 0);
        bad_cnt = 0;
        for (int i = 0; i < log_addr.size(); i++) begin
            if (log_addr[i] == 11 || log_addr[i] == 12) bad_cnt++;
        end
        check_eq("t6_discarded", bad_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
